// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that funnels fetch and data requests into one memory access unit.
// Each accepted access takes three cycles: latch in IDLE, issue, then respond.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [31:0] f_rdata,
   output logic        f_fault,
   input  logic        d_req,
   input  logic [2:0]  d_op,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_fault,
   output logic [2:0]  mem_op,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_in,
   input  logic [31:0] mem_out,
   input  logic        mem_fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic       LAST_FETCH = 1'b0;
   localparam logic       LAST_DATA  = 1'b1;
   localparam logic [2:0] OP_IDLE    = 3'b011;
   localparam logic [2:0] OP_LW      = 3'b010;

   state_t      state_r;
   logic        last_r;
   logic        who_r;
   logic        store_r;
   logic        prefault_r;
   logic [31:0] lat_addr_r;
   logic [31:0] lat_wdata_r;
   logic [2:0]  mem_op_r;
   logic        f_gnt_r;
   logic        d_gnt_r;
   logic        f_rvalid_r;
   logic        d_rvalid_r;

   logic        pick_f_s;
   logic        pick_d_s;
   logic [2:0]  sel_op_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic [31:0] resp_data_s;
   logic        resp_fault_s;

   // Invalid size codes and misaligned half/word accesses never reach memory.
   function automatic logic pre_fault_f(input logic [2:0] op, input logic [1:0] addr_lo);
      logic bad;
      case (op[1:0])
         2'b00:   bad = 1'b0;
         2'b01:   bad = addr_lo[0];
         2'b10:   bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Round-robin winner selection and the request fields to latch.
   always_comb begin
      pick_f_s    = 1'b0;
      pick_d_s    = 1'b0;
      if (f_req && (!d_req || (last_r == LAST_DATA))) begin
         pick_f_s = 1'b1;
      end else if (d_req) begin
         pick_d_s = 1'b1;
      end else begin
         pick_f_s = 1'b0;
      end
      if (pick_f_s) begin
         sel_op_s    = OP_LW;
         sel_addr_s  = f_addr;
         sel_wdata_s = 32'h0000_0000;
      end else begin
         sel_op_s    = d_op;
         sel_addr_s  = d_addr;
         sel_wdata_s = d_wdata;
      end
   end

   // Access sequencer; reset drops mem_op to idle at once so an aborted store never commits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         last_r      <= LAST_DATA;
         who_r       <= 1'b0;
         store_r     <= 1'b0;
         prefault_r  <= 1'b0;
         lat_addr_r  <= 32'h0000_0000;
         lat_wdata_r <= 32'h0000_0000;
         mem_op_r    <= OP_IDLE;
         f_gnt_r     <= 1'b0;
         d_gnt_r     <= 1'b0;
         f_rvalid_r  <= 1'b0;
         d_rvalid_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_f_s || pick_d_s) begin
                  state_r     <= ISSUE;
                  last_r      <= pick_d_s;
                  who_r       <= pick_d_s;
                  store_r     <= sel_op_s[2];
                  prefault_r  <= pre_fault_f(sel_op_s, sel_addr_s[1:0]);
                  lat_addr_r  <= sel_addr_s;
                  lat_wdata_r <= sel_wdata_s;
                  mem_op_r    <= pre_fault_f(sel_op_s, sel_addr_s[1:0]) ? OP_IDLE : sel_op_s;
                  f_gnt_r     <= pick_f_s;
                  d_gnt_r     <= pick_d_s;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               state_r    <= RESP;
               mem_op_r   <= OP_IDLE;
               f_gnt_r    <= 1'b0;
               d_gnt_r    <= 1'b0;
               f_rvalid_r <= ~who_r;
               d_rvalid_r <= who_r;
            end
            RESP: begin
               state_r    <= IDLE;
               f_rvalid_r <= 1'b0;
               d_rvalid_r <= 1'b0;
            end
            default: begin
               state_r    <= IDLE;
               mem_op_r   <= OP_IDLE;
               f_gnt_r    <= 1'b0;
               d_gnt_r    <= 1'b0;
               f_rvalid_r <= 1'b0;
               d_rvalid_r <= 1'b0;
            end
         endcase
      end
   end

   // Memory result arrives during RESP, so the response data path is gated by the registered strobe.
   always_comb begin
      if (store_r || prefault_r) begin
         resp_data_s = 32'h0000_0000;
      end else begin
         resp_data_s = mem_out;
      end
      resp_fault_s = mem_fault | prefault_r;
   end

   assign f_gnt    = f_gnt_r;
   assign d_gnt    = d_gnt_r;
   assign f_rvalid = f_rvalid_r;
   assign d_rvalid = d_rvalid_r;
   assign f_rdata  = f_rvalid_r ? resp_data_s : 32'h0000_0000;
   assign d_rdata  = d_rvalid_r ? resp_data_s : 32'h0000_0000;
   assign f_fault  = f_rvalid_r & resp_fault_s;
   assign d_fault  = d_rvalid_r & resp_fault_s;
   assign mem_op   = mem_op_r;
   assign mem_addr = lat_addr_r;
   assign mem_in   = lat_wdata_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address/data and 3-bit op.
REQ-002 The port `clk` SHALL be an input of width 1 and is the single clock; all state updates on its rising edge.
REQ-003 The port `rst_n` SHALL be an input of width 1 and is the asynchronous, active-low reset.
REQ-004 The port `f_req` SHALL be an input of width 1: fetch requester asks for a word load.
REQ-005 The port `f_addr` SHALL be an input of width 32: fetch address, held stable while `f_req`=1 until `f_gnt`.
REQ-006 The port `f_gnt` SHALL be an output of width 1: one-cycle pulse, fetch request accepted.
REQ-007 The ports `f_rvalid`, `f_rdata` and `f_fault` SHALL be outputs of widths 1, 32 and 1 respectively: fetch response strobe, data and fault.
REQ-008 The port `d_req` SHALL be an input of width 1: data requester asks for a load or store.
REQ-009 The ports `d_op`, `d_addr` and `d_wdata` SHALL be inputs of widths 3, 32 and 32 respectively: op encoding, address and store data, held stable until `d_gnt`.
- Op encoding: bit2 = store; 00 = byte; 01 = half; 10 = word; 11 = invalid.
REQ-010 The port `d_gnt` SHALL be an output of width 1: one-cycle pulse, data request accepted.
REQ-011 The ports `d_rvalid`, `d_rdata` and `d_fault` SHALL be outputs of widths 1, 32 and 1 respectively: data response strobe, data and fault.
REQ-012 The ports `mem_op`, `mem_addr` and `mem_in` SHALL be outputs of widths 3, 32 and 32 respectively, driving the memory access unit.
REQ-013 The ports `mem_out` and `mem_fault` SHALL be inputs of widths 32 and 1 respectively: memory unit results, registered one cycle after the op is presented.

Function
REQ-014 The FSM SHALL have three states, IDLE, ISSUE and RESP, with sequence IDLE -> ISSUE -> RESP -> IDLE; every accepted access therefore takes exactly 3 cycles.
REQ-015 In IDLE with any request pending, the block SHALL select a winner, latch its op/addr/wdata into internal registers and go to ISSUE.
- A fetch is latched as op 3'b010.
- With no request pending, the block SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin.
- Register `last` records the requester most recently granted.
- When both requests are pending, the requester that is not `last` wins.
- A single requester always wins.
- `last` resets to data, so fetch wins the first tie after reset.
REQ-017 In ISSUE, the block SHALL pulse the winner's gnt for one cycle.
- It SHALL drive `mem_addr` and `mem_in` from the latched registers.
- It SHALL drive `mem_op` from the latched op, unless the access is pre-faulted (REQ-019).
REQ-018 In RESP, the winner's rvalid SHALL pulse for one cycle.
- rdata SHALL equal `mem_out` for loads and 0 for stores.
- fault SHALL equal `mem_fault` OR pre-fault.
REQ-019 A latched access SHALL be pre-faulted if its op is 011 or 111, or if it is a half access with addr[0]=1, or a word access with addr[1:0]≠0.
- A pre-faulted access SHALL drive `mem_op` = 3'b011 (idle) in ISSUE, so memory is never written.
- Its response SHALL be fault=1, rdata=0.
REQ-020 Whenever the FSM is not in ISSUE, `mem_op` SHALL be 3'b011 (a non-store, invalid load); `mem_fault` and `mem_out` are ignored outside RESP.
REQ-021 rvalid/rdata/fault of the non-winning port SHALL be 0; rdata/fault of the winning port SHALL be 0 whenever its rvalid is 0.
REQ-022 A request that drops before gnt SHALL NOT be latched again; a request already latched in IDLE SHALL complete even if req deasserts.
REQ-023 A requester holding req high continuously SHALL be served every 3 cycles when alone; when the other requester is also busy, the two alternate every 3 cycles.
REQ-024 A request asserted in the same cycle as RESP SHALL be considered in the following IDLE cycle, not earlier.

Reset
REQ-025 When `rst_n`=0, the block SHALL immediately force state=IDLE, `last`=data, all gnt/rvalid/rdata/fault outputs=0, `mem_op`=3'b011, `mem_addr`=0, `mem_in`=0, and latched registers=0.
REQ-026 A reset asserted during ISSUE SHALL abort the access; because `mem_op` is forced idle asynchronously, no store commits at the next edge, and no response is produced.
REQ-027 After `rst_n` rises, the first arbitration SHALL occur in the first IDLE cycle.

Verification
REQ-028 Fetch only, f_addr=0x10, mem_out=0xDEADBEEF -> `f_gnt` at cycle 1, `mem_op`=010, `f_rvalid` at cycle 2 with `f_rdata`=0xDEADBEEF, `f_fault`=0.
REQ-029 Simultaneous `f_req`/`d_req` after reset, both held -> grants fetch, data, fetch, data at cycles 1, 4, 7, 10.
REQ-030 d_op=110, d_addr=0x22 -> `mem_op`=011 in ISSUE, `d_rvalid`=1, `d_fault`=1, `d_rdata`=0; a subsequent LW at 0x20 returns the unchanged prior contents.
REQ-031 SB d_addr=0x05, d_wdata=0xAB, then LB 0x05 -> store response fault=0, rdata=0; load `d_rdata`=0x000000AB.
REQ-032 d_op=011 -> `d_fault`=1, `mem_op` never leaves 011; d_op=111 gives the same result.
REQ-033 SW 0x40 of 0x12345678 with `rst_n` pulsed low during ISSUE -> no `d_rvalid`; LW 0x40 afterwards returns the old value, and all outputs read 0 during reset.
